// File: rtl/fp4_mul_stage_if.sv
// Operand/product handshake bundle for the FP4 multiplier stage.
// master = upstream driver plus product consumer, slave = the multiplier stage.
interface fp4_mul_stage_if;
  logic       i_valid;
  logic       o_ready;
  logic [3:0] i_a;
  logic [3:0] i_b;
  logic       o_valid;
  logic       i_out_ready;
  logic [3:0] o_prod;
  logic       o_first;
  logic       o_last;

  modport master (
    output i_valid, i_a, i_b, i_out_ready,
    input  o_ready, o_valid, o_prod, o_first, o_last
  );

  modport slave (
    input  i_valid, i_a, i_b, i_out_ready,
    output o_ready, o_valid, o_prod, o_first, o_last
  );
endinterface

// File: rtl/fp4_mul_stage.sv
// Two-stage E2M1 (FP4) multiplier with valid/ready handshake and vector first/last tags.
// Optional saturated-product counter enabled by defining FP4_MUL_SAT_STATS_EN.
module fp4_mul_stage #(
  parameter  int VEC_LEN = 8,
  localparam int CNT_W   = $clog2(VEC_LEN)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_flush,
  fp4_mul_stage_if.slave       bus,
  output logic [15:0]          o_sat_count
);

  // Handshake: a pair moves in when i_valid & o_ready, a product moves out when
  // o_valid & i_out_ready; flush takes priority over both transfers.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);

  // E2M1 magnitude {exp, man} expressed as an integer count of halves (0..12).
  function automatic logic [3:0] to_halves(input logic [2:0] m);
    logic [3:0] h;
    if (m[2:1] == 2'b00) h = {3'b000, m[0]};
    else                 h = {2'b00, 1'b1, m[0]} << (m[2:1] - 2'd1);
    return h;
  endfunction

  // Quarters to nearest E2M1 magnitude code; ties resolve to the even code.
  function automatic logic [2:0] round_q(input logic [7:0] q);
    logic [2:0] c;
    if      (q <= 8'd1)  c = 3'd0;
    else if (q == 8'd2)  c = 3'd1;
    else if (q <= 8'd5)  c = 3'd2;
    else if (q == 8'd6)  c = 3'd3;
    else if (q <= 8'd10) c = 3'd4;
    else if (q <= 8'd13) c = 3'd5;
    else if (q <= 8'd20) c = 3'd6;
    else                 c = 3'd7;
    return c;
  endfunction

  logic             s1_valid;
  logic [7:0]       s1_q;
  logic             s1_sign;
  logic             s1_first;
  logic             s1_last;
  logic [CNT_W-1:0] elem_cnt;

  logic             s2_load;
  logic             in_xfer;
  logic [7:0]       prod_q;
  logic [2:0]       s2_mag;

  assign s2_load     = !bus.o_valid || bus.i_out_ready;
  assign bus.o_ready = !s1_valid || s2_load;
  assign in_xfer     = bus.i_valid && bus.o_ready;
  assign prod_q      = {4'b0000, to_halves(bus.i_a[2:0])} * {4'b0000, to_halves(bus.i_b[2:0])};
  assign s2_mag      = round_q(s1_q);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid    <= 1'b0;
      s1_q        <= 8'd0;
      s1_sign     <= 1'b0;
      s1_first    <= 1'b0;
      s1_last     <= 1'b0;
      elem_cnt    <= '0;
      bus.o_valid <= 1'b0;
      bus.o_prod  <= 4'd0;
      bus.o_first <= 1'b0;
      bus.o_last  <= 1'b0;
    end else if (i_flush) begin
      s1_valid    <= 1'b0;
      bus.o_valid <= 1'b0;
      elem_cnt    <= '0;
    end else begin
      if (bus.o_ready) s1_valid <= in_xfer;
      if (in_xfer) begin
        s1_q     <= prod_q;
        s1_sign  <= bus.i_a[3] ^ bus.i_b[3];
        s1_first <= (elem_cnt == '0);
        s1_last  <= (elem_cnt == LAST_IDX);
        elem_cnt <= (elem_cnt == LAST_IDX) ? '0 : elem_cnt + CNT_W'(1);
      end
      if (s2_load) begin
        bus.o_valid <= s1_valid;
        if (s1_valid) begin
          // A zero magnitude is always emitted as +0.
          bus.o_prod  <= {s1_sign && (s2_mag != 3'd0), s2_mag};
          bus.o_first <= s1_first;
          bus.o_last  <= s1_last;
        end
      end
    end
  end

`ifdef FP4_MUL_SAT_STATS_EN
  logic s1_sat;
  logic s2_sat;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_sat      <= 1'b0;
      s2_sat      <= 1'b0;
      o_sat_count <= 16'h0000;
    end else if (!i_flush) begin
      if (in_xfer) s1_sat <= (prod_q > 8'd24);
      if (s2_load && s1_valid) s2_sat <= s1_sat;
      // Counted on output transfer so stalled products are not counted twice.
      if (bus.o_valid && bus.i_out_ready && s2_sat && (o_sat_count != 16'hFFFF))
        o_sat_count <= o_sat_count + 16'd1;
    end
  end
`else
  assign o_sat_count = 16'h0000;
`endif

endmodule
